// File: rtl/cpuc_quad_ram_arbiter_pkg.sv
// CPUC shared constants and RAM port bundles.
// MEM_SIZE, port count, per-port request and response records.
package cpuc_package;

  localparam int MEM_SIZE       = 256;
  localparam int CPUC_RAM_PORTS = 4;
  localparam int CPUC_ADDR_W    = 32;
  localparam int CPUC_DATA_W    = 32;

  typedef struct packed {
    logic [CPUC_ADDR_W-1:0] addr;
    logic                   wren;
    logic [CPUC_DATA_W-1:0] data;
  } t_ram_port_req;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [CPUC_DATA_W-1:0] rdata;
  } t_ram_rsp;

endpackage

// File: rtl/cpuc_rr_multi_grant.sv
// Combinational round-robin picker: first four eligible from ptr.
// Ports: elig, ptr in; gnt_oh/gnt_vld per RAM port, last_idx out.
module cpuc_rr_multi_grant
  import cpuc_package::*;
#(
  parameter int NUM_REQ = 6,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                     elig,
  input  logic [PW-1:0]                          ptr,
  output logic [CPUC_RAM_PORTS-1:0][NUM_REQ-1:0] gnt_oh,
  output logic [CPUC_RAM_PORTS-1:0]              gnt_vld,
  output logic [PW-1:0]                          last_idx
);

  int idx;
  int cnt;

  always_comb begin
    gnt_oh   = '0;
    gnt_vld  = '0;
    last_idx = ptr;
    idx      = 0;
    cnt      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (elig[idx] && cnt < CPUC_RAM_PORTS) begin
        gnt_oh[cnt][idx] = 1'b1;
        gnt_vld[cnt]     = 1'b1;
        last_idx         = PW'(idx);
        cnt              = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cpuc_quad_ram_arbiter.sv
// Quad-port RAM arbiter: round-robin grants of NUM_REQ requesters
// onto ports A..D, 1-cycle registered responses.
// Ports: req_* (valid/ready/wren/addr/wdata), rsp_* (valid/err/rdata),
// ram_address/wren/data/q _a.._d. Option: CPUC_RAM_ARB_WR_CONFLICT_EN
// defers a write hitting the address of an earlier granted write.
module cpuc_quad_ram_arbiter
  import cpuc_package::*;
#(
  parameter int NUM_REQ    = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_wren,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [NUM_REQ-1:0]                    rsp_err,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    rsp_rdata,
  output logic [ADDR_WIDTH-1:0]                 ram_address_a,
  output logic [ADDR_WIDTH-1:0]                 ram_address_b,
  output logic [ADDR_WIDTH-1:0]                 ram_address_c,
  output logic [ADDR_WIDTH-1:0]                 ram_address_d,
  output logic                                  ram_wren_a,
  output logic                                  ram_wren_b,
  output logic                                  ram_wren_c,
  output logic                                  ram_wren_d,
  output logic [DATA_WIDTH-1:0]                 ram_data_a,
  output logic [DATA_WIDTH-1:0]                 ram_data_b,
  output logic [DATA_WIDTH-1:0]                 ram_data_c,
  output logic [DATA_WIDTH-1:0]                 ram_data_d,
  input  logic [DATA_WIDTH-1:0]                 ram_q_a,
  input  logic [DATA_WIDTH-1:0]                 ram_q_b,
  input  logic [DATA_WIDTH-1:0]                 ram_q_c,
  input  logic [DATA_WIDTH-1:0]                 ram_q_d
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int NP = CPUC_RAM_PORTS;
  localparam logic [ADDR_WIDTH-1:0] MEM_LIM = ADDR_WIDTH'(MEM_SIZE);

  logic [PW-1:0]                        rr_ptr;
  logic [PW-1:0]                        last_idx;
  logic [NUM_REQ-1:0]                   elig;
  logic [NUM_REQ-1:0]                   in_range;
  logic [NP-1:0][NUM_REQ-1:0]           gnt_oh;
  logic [NP-1:0]                        gnt_vld;
  logic [NP-1:0][ADDR_WIDTH-1:0]        p_addr;
  logic [NP-1:0]                        p_wren;
  logic [NP-1:0][DATA_WIDTH-1:0]        p_data;
  logic [NP-1:0][DATA_WIDTH-1:0]        ram_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rdata_nxt;

  always_comb begin
    in_range = '0;
    for (int i = 0; i < NUM_REQ; i++)
      in_range[i] = req_addr[i] < MEM_LIM;
  end

`ifdef CPUC_RAM_ARB_WR_CONFLICT_EN
  // Walk the scan order once, tracking addresses of writes already
  // taken this cycle; a later write to one of them sits out.
  int                        n;
  int                        idx;
  logic                      hit;
  logic [NP-1:0][ADDR_WIDTH-1:0] wa;
  logic [NP-1:0]             wa_vld;

  always_comb begin
    elig   = '0;
    n      = 0;
    idx    = 0;
    hit    = 1'b0;
    wa     = '0;
    wa_vld = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      hit = 1'b0;
      if (!rst && req_valid[idx] && n < NP) begin
        for (int m = 0; m < NP; m++)
          if (m < n && wa_vld[m] && req_wren[idx] &&
              wa[m] == req_addr[idx])
            hit = 1'b1;
        if (!hit) begin
          elig[idx]  = 1'b1;
          wa[n]      = req_addr[idx];
          wa_vld[n]  = req_wren[idx];
          n          = n + 1;
        end
      end
    end
  end
`else
  always_comb begin
    elig = rst ? '0 : req_valid;
  end
`endif

  cpuc_rr_multi_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .elig     (elig),
    .ptr      (rr_ptr),
    .gnt_oh   (gnt_oh),
    .gnt_vld  (gnt_vld),
    .last_idx (last_idx)
  );

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NP; k++)
      if (gnt_vld[k]) req_ready = req_ready | gnt_oh[k];
  end

  // Out-of-range requests still occupy a port but never write.
  always_comb begin
    p_addr = '0;
    p_wren = '0;
    p_data = '0;
    for (int k = 0; k < NP; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt_oh[k][i]) begin
          p_addr[k] = req_addr[i];
          p_wren[k] = req_wren[i] && in_range[i];
          p_data[k] = req_wdata[i];
        end
  end

  assign ram_address_a = p_addr[0];
  assign ram_address_b = p_addr[1];
  assign ram_address_c = p_addr[2];
  assign ram_address_d = p_addr[3];
  assign ram_wren_a    = p_wren[0];
  assign ram_wren_b    = p_wren[1];
  assign ram_wren_c    = p_wren[2];
  assign ram_wren_d    = p_wren[3];
  assign ram_data_a    = p_data[0];
  assign ram_data_b    = p_data[1];
  assign ram_data_c    = p_data[2];
  assign ram_data_d    = p_data[3];

  assign ram_q = {ram_q_d, ram_q_c, ram_q_b, ram_q_a};

  always_comb begin
    rdata_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < NP; k++)
        if (gnt_oh[k][i] && !req_wren[i] && in_range[i])
          rdata_nxt[i] = ram_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
    end else begin
      if (|gnt_vld)
        rr_ptr <= (last_idx == PW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
      rsp_valid <= req_ready;
      rsp_err   <= req_ready & ~in_range;
      rsp_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_cpuc_quad_ram_arbiter.sv
// Directed bench for cpuc_quad_ram_arbiter with a behavioural
// 4-port RAM (pre-write reads, D > C > B > A write priority).
module tb_cpuc_quad_ram_arbiter;

  localparam int N  = 6;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           req_wren;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic [N-1:0]           rsp_valid;
  logic [N-1:0]           rsp_err;
  logic [N-1:0][DW-1:0]   rsp_rdata;
  logic [AW-1:0] ram_address_a, ram_address_b, ram_address_c, ram_address_d;
  logic          ram_wren_a, ram_wren_b, ram_wren_c, ram_wren_d;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_data_c, ram_data_d;
  logic [DW-1:0] ram_q_a, ram_q_b, ram_q_c, ram_q_d;

  logic [DW-1:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpuc_quad_ram_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wren      (req_wren),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_rdata     (rsp_rdata),
    .ram_address_a (ram_address_a),
    .ram_address_b (ram_address_b),
    .ram_address_c (ram_address_c),
    .ram_address_d (ram_address_d),
    .ram_wren_a    (ram_wren_a),
    .ram_wren_b    (ram_wren_b),
    .ram_wren_c    (ram_wren_c),
    .ram_wren_d    (ram_wren_d),
    .ram_data_a    (ram_data_a),
    .ram_data_b    (ram_data_b),
    .ram_data_c    (ram_data_c),
    .ram_data_d    (ram_data_d),
    .ram_q_a       (ram_q_a),
    .ram_q_b       (ram_q_b),
    .ram_q_c       (ram_q_c),
    .ram_q_d       (ram_q_d)
  );

  // RAM model; preloaded during reset: mem[i] = 0x100+i, mem[20] = 0x11.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h100 + i;
      mem[20] <= 32'h11;
    end else begin
      if (ram_wren_a && ram_address_a < 256) mem[ram_address_a[7:0]] <= ram_data_a;
      if (ram_wren_b && ram_address_b < 256) mem[ram_address_b[7:0]] <= ram_data_b;
      if (ram_wren_c && ram_address_c < 256) mem[ram_address_c[7:0]] <= ram_data_c;
      if (ram_wren_d && ram_address_d < 256) mem[ram_address_d[7:0]] <= ram_data_d;
    end
  end

  assign ram_q_a = (ram_address_a < 256) ? mem[ram_address_a[7:0]] : '0;
  assign ram_q_b = (ram_address_b < 256) ? mem[ram_address_b[7:0]] : '0;
  assign ram_q_c = (ram_address_c < 256) ? mem[ram_address_c[7:0]] : '0;
  assign ram_q_d = (ram_address_d < 256) ? mem[ram_address_d[7:0]] : '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_wren  = '1;
    req_wdata = '0;
    for (int i = 0; i < N; i++) req_addr[i] = AW'(i);
    #2;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wren", 64'({ram_wren_d, ram_wren_c, ram_wren_b, ram_wren_a}), 64'h0);
    step();
    step();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_rsp_rdata0", 64'(rsp_rdata[0]), 64'h0);
    chk("rst_ptr", 64'(dut.rr_ptr), 64'h0);

    // six reads of 10..15
    rst      = 1'b0;
    req_wren = '0;
    for (int i = 0; i < N; i++) req_addr[i] = AW'(10 + i);
    #1;
    chk("rr0_ready", 64'(req_ready), 64'h0f);
    chk("rr0_addr_a", 64'(ram_address_a), 64'd10);
    chk("rr0_addr_d", 64'(ram_address_d), 64'd13);
    step();
    chk("rr0_rsp_valid", 64'(rsp_valid), 64'h0f);
    chk("rr0_rdata0", 64'(rsp_rdata[0]), 64'h10a);
    chk("rr0_rdata3", 64'(rsp_rdata[3]), 64'h10d);
    chk("rr0_ptr", 64'(dut.rr_ptr), 64'd4);
    req_valid = 6'b110000;
    #1;
    chk("rr1_ready", 64'(req_ready), 64'h30);
    chk("rr1_addr_a", 64'(ram_address_a), 64'd14);
    chk("rr1_addr_b", 64'(ram_address_b), 64'd15);
    chk("rr1_addr_c_idle", 64'(ram_address_c), 64'd0);
    step();
    chk("rr1_rsp_valid", 64'(rsp_valid), 64'h30);
    chk("rr1_rdata4", 64'(rsp_rdata[4]), 64'h10e);
    chk("rr1_rdata5", 64'(rsp_rdata[5]), 64'h10f);
    chk("rr1_ptr_wrap", 64'(dut.rr_ptr), 64'd0);

    // write then read back
    req_valid    = 6'b000100;
    req_wren     = 6'b000100;
    req_addr[2]  = 32'd7;
    req_wdata[2] = 32'hdead_beef;
    #1;
    chk("wr_ready", 64'(req_ready), 64'h04);
    chk("wr_wren_a", 64'(ram_wren_a), 64'h1);
    step();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'h04);
    chk("wr_rdata", 64'(rsp_rdata[2]), 64'h0);
    chk("wr_ptr", 64'(dut.rr_ptr), 64'd3);
    req_wren = '0;
    step();
    chk("rd7_rdata", 64'(rsp_rdata[2]), 64'hdead_beef);

    // same-cycle read and write of address 20
    req_valid    = 6'b001010;
    req_wren     = 6'b001000;
    req_addr[1]  = 32'd20;
    req_addr[3]  = 32'd20;
    req_wdata[3] = 32'h22;
    #1;
    chk("rw_ready", 64'(req_ready), 64'h0a);
    chk("rw_wren_a", 64'(ram_wren_a), 64'h1);
    step();
    chk("rw_rsp_valid", 64'(rsp_valid), 64'h0a);
    chk("rw_rdata1_old", 64'(rsp_rdata[1]), 64'h11);
    chk("rw_rdata3", 64'(rsp_rdata[3]), 64'h0);
    chk("rw_ptr", 64'(dut.rr_ptr), 64'd2);
    req_valid = 6'b000010;
    req_wren  = '0;
    step();
    chk("rw_rdata1_new", 64'(rsp_rdata[1]), 64'h22);

    // two writes to address 5
    req_valid    = 6'b000011;
    req_wren     = 6'b000011;
    req_addr[0]  = 32'd5;
    req_addr[1]  = 32'd5;
    req_wdata[0] = 32'ha;
    req_wdata[1] = 32'hb;
    #1;
`ifdef CPUC_RAM_ARB_WR_CONFLICT_EN
    chk("col_ready0", 64'(req_ready), 64'h01);
    step();
    chk("col_mem_mid", 64'(mem[5]), 64'ha);
    chk("col_ptr_mid", 64'(dut.rr_ptr), 64'd1);
    req_valid = 6'b000010;
    #1;
    chk("col_ready1", 64'(req_ready), 64'h02);
    step();
`else
    chk("col_ready", 64'(req_ready), 64'h03);
    step();
`endif
    req_valid = '0;
    req_wren  = '0;
    chk("col_mem5", 64'(mem[5]), 64'hb);
    chk("col_ptr", 64'(dut.rr_ptr), 64'd2);

    // out-of-range read and write
    req_valid    = 6'b110000;
    req_wren     = 6'b100000;
    req_addr[4]  = 32'd256;
    req_addr[5]  = 32'd256;
    req_wdata[5] = 32'h55;
    #1;
    chk("oor_ready", 64'(req_ready), 64'h30);
    chk("oor_wren", 64'({ram_wren_b, ram_wren_a}), 64'h0);
    step();
    chk("oor_rsp_valid", 64'(rsp_valid), 64'h30);
    chk("oor_rsp_err", 64'(rsp_err), 64'h30);
    chk("oor_rdata4", 64'(rsp_rdata[4]), 64'h0);
    chk("oor_ptr", 64'(dut.rr_ptr), 64'd0);

    // reset with four grants in flight
    req_valid   = 6'b000010;
    req_wren    = '0;
    req_addr[1] = 32'd10;
    step();
    chk("pre_rst_ptr", 64'(dut.rr_ptr), 64'd2);
    req_valid = '1;
    for (int i = 0; i < N; i++) req_addr[i] = AW'(10 + i);
    #1;
    chk("pre_rst_ready", 64'(req_ready), 64'h3c);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    step();
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("post_rst_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(req_ready), 64'h0f);
    step();
    chk("rel_rsp_valid", 64'(rsp_valid), 64'h0f);
    chk("rel_rdata0", 64'(rsp_rdata[0]), 64'h10a);
    req_valid = '0;
    step();
    chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
